lcd_pixel_gen: RTL and testbench

Pixel source directly downstream of LCD_SYNC. It consumes DEN, VD, Columna and Fila, and produces registered 24-bit RGB for the 800x480 panel. A 4-pattern FSM steps through colour bars, grid, gradient and a bouncing box. Pattern and box state update only at frame boundaries, so a frame never tears.

---
 rtl/lcd_pixel_gen.sv | 131 +++++++++++++
 tb/tb_lcd_pixel_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_gen.sv
// lcd_pixel_gen: 800x480 test-pattern source (bars/grid/gradient/bouncing box), 1-cycle latency.
// Define PIXGEN_BORDER_EN to overlay a 2-pixel green border on every pattern.
module lcd_pixel_gen #(
    parameter int H_ACTIVE           = 800,
    parameter int V_ACTIVE           = 480,
    parameter int BOX_SIZE           = 64,
    parameter int STEP               = 2,
    parameter int FRAMES_PER_PATTERN = 120
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        DEN,
    input  logic        VD,
    input  logic [10:0] Columna,
    input  logic [9:0]  Fila,
    input  logic        NEXT,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        DEN_O,
    output logic [1:0]  PATTERN
);
    typedef enum logic [1:0] {BARS, GRID, GRAD, BOX} pat_t;

    localparam int CW = $clog2(FRAMES_PER_PATTERN);
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_PATTERN - 1);
    localparam logic signed [11:0] X_MAX = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic signed [11:0] ST = 12'(STEP);
    localparam logic signed [11:0] BS = 12'(BOX_SIZE);

    pat_t state, state_nx;
    logic vd_d, pend, tick, advance;
    logic [CW-1:0] cnt;
    logic signed [11:0] x, y, x_step, y_step, col, row;
    logic x_neg, y_neg;
    logic [2:0] bar;
    logic grid_on, in_box;
    logic [23:0] pix, pix_o;

    assign tick    = vd_d & ~VD;
    assign advance = tick & (pend | NEXT | (cnt == LAST));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            vd_d <= 1'b1;
            pend <= 1'b0;
            cnt  <= '0;
        end else begin
            vd_d <= VD;
            if (advance) begin
                pend <= 1'b0;
                cnt  <= '0;
            end else begin
                if (NEXT)
                    pend <= 1'b1;
                if (tick)
                    cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            state <= BARS;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = advance ? pat_t'(state + 2'd1) : state;
    end

    always_comb begin
        PATTERN = state;
    end

    // Reaching a limit exactly already flips direction, so the next step moves away.
    assign x_step = x_neg ? x - ST : x + ST;
    assign y_step = y_neg ? y - ST : y + ST;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            x     <= '0;
            y     <= '0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
        end else if (tick) begin
            x     <= x_step >= X_MAX ? X_MAX : x_step <= 12'sd0 ? 12'sd0 : x_step;
            x_neg <= x_step >= X_MAX ? 1'b1 : x_step <= 12'sd0 ? 1'b0 : x_neg;
            y     <= y_step >= Y_MAX ? Y_MAX : y_step <= 12'sd0 ? 12'sd0 : y_step;
            y_neg <= y_step >= Y_MAX ? 1'b1 : y_step <= 12'sd0 ? 1'b0 : y_neg;
        end
    end

    assign bar     = 3'(Columna / 11'd100);
    assign col     = $signed({1'b0, Columna});
    assign row     = $signed({2'b0, Fila});
    assign grid_on = (Columna[5:0] == 6'd0) || (Fila[5:0] == 6'd0) ||
                     (Columna == 11'(H_ACTIVE - 1)) || (Fila == 10'(V_ACTIVE - 1));
    assign in_box  = (col >= x) && (col < x + BS) && (row >= y) && (row < y + BS);

    // Bar colour bits fall straight out of the bar index: R=~i[1], G=~i[2], B=~i[0].
    always_comb begin
        pix = state == BARS ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} :
              state == GRID ? {24{grid_on}} :
              state == GRAD ? {Columna[9:2], Fila[8:1], 8'h80} :
              in_box        ? 24'hFF0000 : 24'h000040;
    end

`ifdef PIXGEN_BORDER_EN
    always_comb begin
        pix_o = (Columna < 11'd2 || Columna >= 11'(H_ACTIVE - 2) ||
                 Fila < 10'd2 || Fila >= 10'(V_ACTIVE - 2)) ? 24'h00FF00 : pix;
    end
`else
    always_comb begin
        pix_o = pix;
    end
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            {R, G, B} <= '0;
            DEN_O     <= 1'b0;
        end else begin
            {R, G, B} <= DEN ? pix_o : 24'h0;
            DEN_O     <= DEN;
        end
    end
endmodule

// File: tb/tb_lcd_pixel_gen.sv
// tb_lcd_pixel_gen: scoreboard bench for lcd_pixel_gen; expected pixels come from a behavioural model.
module tb_lcd_pixel_gen;
    logic        CLK = 1'b0, RST_n = 1'b0, DEN = 1'b0, VD = 1'b1, NEXT = 1'b0;
    logic [10:0] Columna = '0;
    logic [9:0]  Fila = '0;
    logic [7:0]  R, G, B;
    logic        DEN_O;
    logic [1:0]  PATTERN;

    int errors = 0;
    int checks = 0;
    logic [24:0] q[$];
    int m_pat, m_cnt, m_x, m_y;
    bit m_pend, m_xneg, m_yneg;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    lcd_pixel_gen dut (
        .CLK(CLK), .RST_n(RST_n), .DEN(DEN), .VD(VD), .Columna(Columna), .Fila(Fila),
        .NEXT(NEXT), .R(R), .G(G), .B(B), .DEN_O(DEN_O), .PATTERN(PATTERN)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        logic [24:0] e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({R, G, B, DEN_O} !== e) begin
                errors++;
                $display("FAIL pixel: got rgb=%h den_o=%b, want rgb=%h den_o=%b",
                         {R, G, B}, DEN_O, e[24:1], e[0]);
            end
        end
    end

    function automatic logic [24:0] exp_pix(int c, int r, bit den);
        logic [23:0] p;
        if (!den)
            return 25'd0;
        case (m_pat)
            0: p = bars[c / 100];
            1: p = (c % 64 == 0 || r % 64 == 0 || c == 799 || r == 479) ? 24'hFFFFFF : 24'h000000;
            2: p = {8'(c / 4), 8'(r / 2), 8'h80};
            default: p = (c >= m_x && c < m_x + 64 && r >= m_y && r < m_y + 64) ? 24'hFF0000 : 24'h000040;
        endcase
`ifdef PIXGEN_BORDER_EN
        if (c < 2 || c >= 798 || r < 2 || r >= 478)
            p = 24'h00FF00;
`endif
        return {p, 1'b1};
    endfunction

    task automatic pixel(int c, int r, bit den);
        Columna = 11'(c);
        Fila    = 10'(r);
        DEN     = den;
        @(posedge CLK);
        q.push_back(exp_pix(c, r, den));
        #1;
        DEN = 1'b0;
    endtask

    task automatic do_reset();
        #5;
        RST_n = 1'b0;
        DEN   = 1'b0;
        VD    = 1'b1;
        NEXT  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({R, G, B, DEN_O, PATTERN} !== 27'd0) begin
            errors++;
            $display("FAIL reset: got rgb=%h den_o=%b pattern=%0d, want all zero", {R, G, B}, DEN_O, PATTERN);
        end
        m_pat = 0; m_cnt = 0; m_x = 0; m_y = 0;
        m_pend = 0; m_xneg = 0; m_yneg = 0;
        RST_n = 1'b1;
    endtask

    task automatic tick(bit nxt);
        VD   = 1'b0;
        NEXT = nxt;
        DEN  = 1'b0;
        @(posedge CLK);
        if (m_pend || nxt || m_cnt == 119) begin
            m_pat = (m_pat + 1) % 4;
            m_cnt = 0;
            m_pend = 0;
        end else
            m_cnt++;
        m_x += m_xneg ? -2 : 2;
        if (m_x >= 736) begin m_x = 736; m_xneg = 1; end
        else if (m_x <= 0) begin m_x = 0; m_xneg = 0; end
        m_y += m_yneg ? -2 : 2;
        if (m_y >= 416) begin m_y = 416; m_yneg = 1; end
        else if (m_y <= 0) begin m_y = 0; m_yneg = 0; end
        #1;
        VD   = 1'b1;
        NEXT = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (PATTERN !== 2'(m_pat)) begin
            errors++;
            $display("FAIL pattern_tick: got %0d, want %0d", PATTERN, m_pat);
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++)
            tick(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        pixel(0, 10, 1);
        pixel(150, 10, 1);
        pixel(799, 10, 1);
        checks++;
        if (PATTERN !== 2'd0) begin
            errors++;
            $display("FAIL reset_pattern: got %0d, want 0", PATTERN);
        end
    endtask

    task automatic test_border();
        pixel(1, 100, 1);
        pixel(2, 100, 1);
        pixel(400, 479, 1);
    endtask

    task automatic test_auto_advance();
        ticks(119);
        tick(1'b0);
        ticks(119);
        pixel(64, 5, 1);
        pixel(65, 5, 1);
        pixel(799, 3, 1);
        pixel(3, 479, 1);
        pixel(130, 300, 1);
    endtask

    task automatic test_next();
        Columna = 11'd300;
        Fila    = 10'd50;
        DEN     = 1'b1;
        NEXT    = 1'b1;
        @(posedge CLK);
        m_pend = 1;
        #1;
        NEXT = 1'b0;
        DEN  = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (PATTERN !== 2'(m_pat)) begin
            errors++;
            $display("FAIL next_midframe: got %0d, want %0d", PATTERN, m_pat);
        end
        tick(1'b0);
        pixel(400, 200, 1);
        pixel(400, 200, 0);
        pixel(13, 101, 1);
        ticks(119);
        tick(1'b1);
        tick(1'b0);
    endtask

    task automatic test_box_x();
        do_reset();
        ticks(368);
        pixel(m_x, m_y, 1);
        pixel(m_x - 1, m_y, 1);
        pixel(m_x + 63, m_y + 63, 1);
        pixel(m_x, m_y + 64, 1);
        tick(1'b0);
        pixel(734, m_y, 1);
        pixel(m_x + 64, m_y, 1);
        pixel(733, m_y, 1);
    endtask

    task automatic test_box_y();
        do_reset();
        ticks(204);
        tick(1'b1);
        tick(1'b1);
        ticks(2);
        pixel(m_x, 416, 1);
        pixel(m_x, m_y - 1, 1);
        pixel(m_x + 63, m_y + 63, 1);
        pixel(m_x + 64, m_y, 1);
        tick(1'b0);
        pixel(m_x, 414, 1);
        pixel(m_x, m_y + 63, 1);
        pixel(m_x, m_y + 64, 1);
    endtask

    task automatic test_reset_midframe();
        Columna = 11'd50;
        Fila    = 10'd100;
        DEN     = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (DEN_O !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_den: got %b, want 1", DEN_O);
        end
        RST_n = 1'b0;
        #1;
        checks++;
        if ({R, G, B, DEN_O, PATTERN} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset: got rgb=%h den_o=%b pattern=%0d, want all zero", {R, G, B}, DEN_O, PATTERN);
        end
        DEN = 1'b0;
        m_pat = 0; m_cnt = 0; m_x = 0; m_y = 0;
        m_pend = 0; m_xneg = 0; m_yneg = 0;
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        pixel(150, 100, 1);
        pixel(650, 100, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_border();
        test_auto_advance();
        test_next();
        test_box_x();
        test_box_y();
        test_reset_midframe();
        #20;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
